// File: rtl/mul8_pkg.sv
// Shared constants and state encoding for the sequential 8x8 shift-and-add multiplier.
package mul8_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ITERS = 8;
  localparam logic [3:0]  LAST_ITER = 4'(ITERS - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    EXEC = 2'd1,
    IDLE = 2'd2,
    HALT = 2'd3
  } state_t;

endpackage

// File: rtl/adder8.sv
// 8-bit unsigned ripple-carry adder built from a chain of full adders.
module adder8 (
  output logic       Cout,
  output logic [7:0] Sum,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin
);

  logic [8:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

  assign Cout = carry[8];

endmodule

// File: rtl/mul8_fsm_adder.sv
// Shift-and-add multiplier core: control FSM, ripple adder and product/multiplier shift registers.
// One INIT cycle followed by eight add-or-shift iterations, then HALT until reset.
module mul8_fsm_adder
  import mul8_pkg::*;
(
  input  logic        clk,
  input  logic        areset,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [15:0] product,
  output logic [1:0]  state,
  output logic        done
);

  state_t      state_q, state_d;
  logic [15:0] prod_q, prod_d;
  logic [7:0]  b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        add_cout;
  logic [7:0]  add_sum;

  // b_q[0] is consumed only through the next-state lookahead on b_q[1]
  logic        unused_b_lsb;
  assign unused_b_lsb = b_q[0];

  adder8 u_adder8 (
    .Cout (add_cout),
    .Sum  (add_sum),
    .A    (prod_q[15:8]),
    .B    (multiplicand),
    .Cin  (1'b0)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= INIT;
      prod_q  <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    prod_d = prod_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      INIT: begin
        prod_d = '0;
        b_d    = multiplier;
        cnt_d  = '0;
      end
      EXEC: begin
        prod_d = {add_cout, add_sum, prod_q[7:1]};
        b_d    = {1'b0, b_q[7:1]};
        cnt_d  = cnt_q + 4'd1;
      end
      IDLE: begin
        prod_d = {1'b0, prod_q[15:1]};
        b_d    = {1'b0, b_q[7:1]};
        cnt_d  = cnt_q + 4'd1;
      end
      HALT: begin
        prod_d = prod_q;
      end
      default: begin
        prod_d = prod_q;
      end
    endcase
  end

  // Next iteration type is decided by the bit that becomes the LSB after this shift
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: state_d = multiplier[0] ? EXEC : IDLE;
      EXEC, IDLE: begin
        if (cnt_q == LAST_ITER) begin
          state_d = HALT;
        end else begin
          state_d = b_q[1] ? EXEC : IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = INIT;
    endcase
  end

  assign product = prod_q;
  assign state   = state_q;
  assign done    = (state_q == HALT);

endmodule

// File: tb/tb_mul8_fsm_adder.sv
// Self-checking bench for mul8_fsm_adder: vector table with a result scoreboard plus corner sequences.
module tb_mul8_fsm_adder;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic [1:0]  state;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[7];

  mul8_fsm_adder dut (
    .clk          (clk),
    .areset       (areset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .state        (state),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset edge, release, then wait (bounded) for done and score the product.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] req);
    int lat;
    areset       = 1'b1;
    multiplicand = a;
    multiplier   = b;
    step();
    check("reset_state", 32'(state), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    areset = 1'b0;
    exp_q.push_back(req);
    lat = 0;
    while (!done && lat < 30) begin
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'd9);
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check("product", 32'(product), 32'(e));
    end
    check("halt_state", 32'(state), 32'd3);
  endtask

  initial begin
    logic [1:0] seq[9];
    logic [15:0] held;

    areset       = 1'b1;
    multiplicand = '0;
    multiplier   = '0;

    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'h0000};
    vecs[3] = '{8'd200, 8'd0,   16'h0000};
    vecs[4] = '{8'd1,   8'd128, 16'h0080};
    vecs[5] = '{8'd128, 8'd1,   16'h0080};
    vecs[6] = '{8'd6,   8'd7,   16'h002A};

    step();
    step();
    check("initial_state", 32'(state), 32'd0);
    check("initial_product", 32'(product), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod);
    end

    // State trace for 13 x 11
    seq = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    areset       = 1'b1;
    multiplicand = 8'd13;
    multiplier   = 8'd11;
    step();
    check("trace_init", 32'(state), 32'd0);
    areset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("trace_%0d", i + 1), 32'(state), 32'(seq[i]));
    end

    // Hold in HALT with operands toggling
    held = product;
    check("hold_start", 32'(held), 32'h008F);
    for (int i = 0; i < 20; i++) begin
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      step();
      check("hold_product", 32'(product), 32'h008F);
      check("hold_done", 32'(done), 32'd1);
    end

    // Abort 37 x 91 at iteration 4, restart with 6 x 7
    areset       = 1'b1;
    multiplicand = 8'd37;
    multiplier   = 8'd91;
    step();
    areset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_busy", 32'(done), 32'd0);
    run_op(8'd6, 8'd7, 16'h002A);

    // Holding reset keeps the core in INIT
    areset       = 1'b1;
    multiplicand = 8'd255;
    multiplier   = 8'd255;
    for (int i = 0; i < 4; i++) begin
      step();
      check("reset_hold_state", 32'(state), 32'd0);
      check("reset_hold_product", 32'(product), 32'd0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
